// File: rtl/sd_sched_pkg.sv
// rtl/sd_sched_pkg.sv - shared types and constants for the SD sector scheduler
// Purpose: state enum, error codes and sector geometry used by sd_sector_sched.
// Ports: none (package).
package sd_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_XFER,
        ST_HOLD,
        ST_FIN
    } sd_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ARG     = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int SECTOR_SHIFT = 9;

    // True when the sector lies inside the mounted image (img_size in bytes).
    function automatic logic lba_in_range(input logic [31:0] lba, input logic [63:0] img_size);
        logic [63:0] sectors;
        sectors = img_size >> SECTOR_SHIFT;
        return {32'd0, lba} < sectors;
    endfunction

endpackage

// File: rtl/sd_sector_sched_rr_arb2.sv
// rtl/sd_sector_sched_rr_arb2.sv - two-input round-robin arbiter
// Purpose: one-hot grant between two requesters; the last winner loses ties.
// Ports:
//   clk_sys, reset : clock and asynchronous active-high reset
//   req[1:0]       : request levels
//   en             : commit strobe; the last-winner register updates when set
//   gnt[1:0]       : combinational one-hot grant (0 when no request)
module rr_arb2 (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // last_q = 1 means requester 1 won most recently, so requester 0 wins ties.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (en && (req != 2'b00)) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sd_sector_sched.sv
// rtl/sd_sector_sched.sv - multi-sector SD read scheduler between two requesters and hps_io
// Purpose: arbitrates requesters, issues sd_rd per sector with auto LBA increment,
//          paces sectors against the single sector buffer, range-checks and times out.
// Ports:
//   clk_sys, reset           : clock, asynchronous active-high reset
//   req, req_lba0/1, req_cnt0/1 : requester levels, start LBA and sector count
//   sec_taken                : granted requester consumed the buffer
//   img_size                 : mounted image size in bytes
//   gnt, busy                : one-hot grant and active flag
//   sec_ready, done, err     : one-cycle status pulses
//   err_code                 : last error, held until the next grant
//   sd_lba, sd_rd, sd_ack    : hps_io block-read handshake
module sd_sector_sched
    import sd_sched_pkg::*;
#(
    parameter int TIMEOUT_W = 24
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] req_lba0,
    input  logic [31:0] req_lba1,
    input  logic [7:0]  req_cnt0,
    input  logic [7:0]  req_cnt1,
    input  logic        sec_taken,
    input  logic [63:0] img_size,
    output logic [1:0]  gnt,
    output logic        sec_ready,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    input  logic        sd_ack
);

    localparam logic [TIMEOUT_W-1:0] TMO_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    sd_state_e            state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic                 busy_q, busy_d;
    logic [31:0]          lba_q, lba_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 sd_rd_q, sd_rd_d;
    logic [31:0]          sd_lba_q, sd_lba_d;
    logic                 sec_ready_q, sec_ready_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           err_code_q, err_code_d;

    logic                 arb_en;
    logic [1:0]           arb_gnt;
    logic                 fail;
    logic [1:0]           fail_code;

    rr_arb2 u_arb (
        .clk_sys (clk_sys),
        .reset   (reset),
        .req     (req),
        .en      (arb_en),
        .gnt     (arb_gnt)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        lba_d       = lba_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        sd_rd_d     = sd_rd_q;
        sd_lba_d    = sd_lba_q;
        sec_ready_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        arb_en      = 1'b0;
        fail        = 1'b0;
        fail_code   = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    arb_en     = 1'b1;
                    gnt_d      = arb_gnt;
                    busy_d     = 1'b1;
                    lba_d      = arb_gnt[1] ? req_lba1 : req_lba0;
                    cnt_d      = arb_gnt[1] ? req_cnt1 : req_cnt0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((img_size == 64'd0) || (cnt_q == 8'd0)) begin
                    fail      = 1'b1;
                    fail_code = ERR_ARG;
                end else if (!lba_in_range(lba_q, img_size)) begin
                    fail      = 1'b1;
                    fail_code = ERR_RANGE;
                end else begin
                    state_d  = ST_ISSUE;
                    sd_rd_d  = 1'b1;
                    sd_lba_d = lba_q;
                    tmo_d    = '0;
                end
            end
            ST_ISSUE: begin
                if (sd_ack) begin
                    sd_rd_d = 1'b0;
                    tmo_d   = '0;
                    state_d = ST_XFER;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                    if (&tmo_d) begin
                        fail      = 1'b1;
                        fail_code = ERR_TIMEOUT;
                    end
                end
            end
            ST_XFER: begin
                if (!sd_ack) begin
                    sec_ready_d = 1'b1;
                    cnt_d       = cnt_q - 8'd1;
                    lba_d       = lba_q + 32'd1;
                    state_d     = ST_HOLD;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                    if (&tmo_d) begin
                        fail      = 1'b1;
                        fail_code = ERR_TIMEOUT;
                    end
                end
            end
            ST_HOLD: begin
                // Next sector is issued only once the buffer has been drained.
                if (sec_taken) begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_FIN;
                    end else if (!lba_in_range(lba_q, img_size)) begin
                        fail      = 1'b1;
                        fail_code = ERR_RANGE;
                    end else begin
                        state_d  = ST_ISSUE;
                        sd_rd_d  = 1'b1;
                        sd_lba_d = lba_q;
                        tmo_d    = '0;
                    end
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fail) begin
            err_d      = 1'b1;
            err_code_d = fail_code;
            sd_rd_d    = 1'b0;
            gnt_d      = 2'b00;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 2'b00;
            busy_q      <= 1'b0;
            lba_q       <= 32'd0;
            cnt_q       <= 8'd0;
            tmo_q       <= '0;
            sd_rd_q     <= 1'b0;
            sd_lba_q    <= 32'd0;
            sec_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            lba_q       <= lba_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            sd_rd_q     <= sd_rd_d;
            sd_lba_q    <= sd_lba_d;
            sec_ready_q <= sec_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign sd_rd     = sd_rd_q;
    assign sd_lba    = sd_lba_q;
    assign sec_ready = sec_ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
